frogger_game_ctrl: RTL and testbench

Game-sequencing controller for the frogger VGA design. Owns the frog position, lane-scroll timebase, lives, score and game state. Turns the active-low push buttons into single-step moves and checks the frog against the lane occupancy returned by the lane datapath. Drives the lane shifters via `lane_step` and the VGA renderer via position, visibility and state outputs.

---
 rtl/frogger_game_ctrl.sv | 174 +++++++++++++++++
 tb/tb_frogger_game_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_game_ctrl.sv
// ============================================================================
// Module   : frogger_game_ctrl
// Brief    : Frogger game sequencer - frog position, lane timebase, lives,
//            score and game state, driven by synchronised push buttons.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frogger_game_ctrl #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int LIVES       = 3,
  parameter int DEATH_TICKS = 4,
  parameter int WIN_TICKS   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic [7:0] row_occ,
  output logic [2:0] frog_row,
  output logic [7:0] frog_col,
  output logic       lane_step,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [2:0] game_state,
  output logic       frog_visible
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0] C_START_COL = 8'b0001_0000;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_DYING    = 3'd2,
    S_WIN      = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  state_t           r_state;
  logic [2:0]       r_row;
  logic [7:0]       r_col;
  logic             r_lane_step;
  logic [1:0]       r_lives;
  logic [7:0]       r_score;
  logic             r_visible;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [7:0]       r_phase_ticks;

  // Button vectors are ordered {up, down, right, left}, i.e. move priority.
  logic [3:0] r_btn_s1, r_btn_s2, r_btn_h;
  logic       r_start_s1, r_start_s2, r_start_h;

  logic [3:0] w_press;
  logic       w_start_edge;
  logic       w_tick;
  logic       w_collide;

  assign w_press      = r_btn_h & ~r_btn_s2;
  assign w_start_edge = r_start_s2 & ~r_start_h;
  assign w_tick       = (r_tick_cnt == CNT_W'(TICK_DIV - 1));
  assign w_collide    = (r_row != 3'd0) && (r_row != 3'd7) && ((row_occ & r_col) != 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_row         <= 3'd7;
      r_col         <= C_START_COL;
      r_lane_step   <= 1'b0;
      r_lives       <= 2'(LIVES);
      r_score       <= 8'd0;
      r_visible     <= 1'b1;
      r_tick_cnt    <= '0;
      r_phase_ticks <= 8'd0;
      r_btn_s1      <= 4'hF;
      r_btn_s2      <= 4'hF;
      r_btn_h       <= 4'hF;
      r_start_s1    <= 1'b0;
      r_start_s2    <= 1'b0;
      r_start_h     <= 1'b0;
    end else begin
      r_btn_s1    <= {up, down, right, left};
      r_btn_s2    <= r_btn_s1;
      r_btn_h     <= r_btn_s2;
      r_start_s1  <= start;
      r_start_s2  <= r_start_s1;
      r_start_h   <= r_start_s2;
      r_lane_step <= w_tick && (r_state == S_PLAY);

      if (r_state == S_IDLE || r_state == S_GAMEOVER) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE, S_GAMEOVER: begin
          if (w_start_edge) begin
            r_state <= S_PLAY;
            r_lives <= 2'(LIVES);
            r_score <= 8'd0;
            r_row   <= 3'd7;
            r_col   <= C_START_COL;
          end
        end

        S_PLAY: begin
          if (r_row == 3'd0) begin
            r_state       <= S_WIN;
            r_phase_ticks <= 8'd0;
            if (r_score != 8'hFF) r_score <= r_score + 8'd1;
          end else if (w_collide) begin
            // A press landing in the same cycle is dropped with the frog.
            r_state       <= S_DYING;
            r_phase_ticks <= 8'd0;
            if (r_lives != 2'd0) r_lives <= r_lives - 2'd1;
          end else if (w_press[3]) begin
            r_row <= r_row - 3'd1;
          end else if (w_press[2]) begin
            if (r_row != 3'd7) r_row <= r_row + 3'd1;
          end else if (w_press[1]) begin
            if (r_col != 8'b0000_0001) r_col <= r_col >> 1;
          end else if (w_press[0]) begin
            if (r_col != 8'b1000_0000) r_col <= r_col << 1;
          end
        end

        S_DYING: begin
          if (w_tick) begin
            if (r_phase_ticks == 8'(DEATH_TICKS - 1)) begin
              r_visible     <= 1'b1;
              r_row         <= 3'd7;
              r_col         <= C_START_COL;
              r_phase_ticks <= 8'd0;
              r_state       <= (r_lives == 2'd0) ? S_GAMEOVER : S_PLAY;
            end else begin
              r_visible     <= ~r_visible;
              r_phase_ticks <= r_phase_ticks + 8'd1;
            end
          end
        end

        S_WIN: begin
          if (w_tick) begin
            if (r_phase_ticks == 8'(WIN_TICKS - 1)) begin
              r_row         <= 3'd7;
              r_col         <= C_START_COL;
              r_phase_ticks <= 8'd0;
              r_state       <= S_PLAY;
            end else begin
              r_phase_ticks <= r_phase_ticks + 8'd1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign frog_row     = r_row;
  assign frog_col     = r_col;
  assign lane_step    = r_lane_step;
  assign lives        = r_lives;
  assign score        = r_score;
  assign game_state   = r_state;
  assign frog_visible = r_visible;

endmodule

`default_nettype wire

// File: tb/tb_frogger_game_ctrl.sv
// ============================================================================
// Module   : tb_frogger_game_ctrl
// Brief    : Directed self-checking bench for frogger_game_ctrl (TICK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frogger_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1;
  logic [7:0] row_occ = 8'd0;
  logic [2:0] frog_row;
  logic [7:0] frog_col;
  logic       lane_step;
  logic [1:0] lives;
  logic [7:0] score;
  logic [2:0] game_state;
  logic       frog_visible;

  int tests = 0;
  int fails = 0;

  frogger_game_ctrl #(
    .TICK_DIV(4), .LIVES(3), .DEATH_TICKS(4), .WIN_TICKS(2)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .up(up), .down(down), .left(left), .right(right),
    .row_occ(row_occ),
    .frog_row(frog_row), .frog_col(frog_col), .lane_step(lane_step),
    .lives(lives), .score(score), .game_state(game_state),
    .frog_visible(frog_visible)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 0=up 1=down 2=right 3=left
  task automatic press(input int which);
    case (which)
      0: up = 1'b0;
      1: down = 1'b0;
      2: right = 1'b0;
      default: left = 1'b0;
    endcase
    step(1);
    up = 1'b1; down = 1'b1; right = 1'b1; left = 1'b1;
    step(3);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int limit);
    for (int i = 0; i < limit && game_state !== s; i++) step(1);
    check(tag, game_state, s);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, game_state, 3'd0);
    check({tag, "_row"}, frog_row, 3'd7);
    check({tag, "_col"}, frog_col, 8'h10);
    check({tag, "_lives"}, lives, 2'd3);
    check({tag, "_score"}, score, 8'd0);
    check({tag, "_lstep"}, lane_step, 1'b0);
    check({tag, "_vis"}, frog_visible, 1'b1);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
  endtask

  task automatic up_to_row6_and_hit();
    press(0);
    row_occ = 8'hFF;
    step(1);
    row_occ = 8'h00;
  endtask

  initial begin
    int cnt;
    logic prev_vis;

    #2 reset = 1'b1;
    #2 check_reset_vals("rst");
    reset = 1'b0;
    step(2);

    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (lane_step) cnt++;
    end
    check("idle_no_lstep", cnt, 0);

    start = 1'b1;
    step(1);
    check("start_lat1", game_state, 3'd0);
    start = 1'b0;
    step(1);
    check("start_lat2", game_state, 3'd0);
    step(1);
    check("start_play", game_state, 3'd1);
    check("start_lives", lives, 2'd3);
    check("start_score", score, 8'd0);
    check("start_row", frog_row, 3'd7);
    check("start_col", frog_col, 8'h10);

    step(3);
    check("lstep_lo", lane_step, 1'b0);
    step(1);
    check("lstep_hi", lane_step, 1'b1);
    step(1);
    check("lstep_once", lane_step, 1'b0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (lane_step) cnt++;
    end
    check("lstep_rate", cnt, 3);

    left = 1'b0;
    step(20);
    left = 1'b1;
    step(3);
    check("hold_left_col", frog_col, 8'h20);
    press(3); press(3); press(3);
    check("left_edge_col", frog_col, 8'h80);

    up = 1'b0; right = 1'b0;
    step(1);
    up = 1'b1; right = 1'b1;
    step(3);
    check("prio_row", frog_row, 3'd6);
    check("prio_col", frog_col, 8'h80);

    press(1);
    check("down_row", frog_row, 3'd7);
    press(1);
    check("down_floor", frog_row, 3'd7);

    for (int i = 0; i < 4; i++) press(2);
    press(0); press(0);
    check("pos_row5", frog_row, 3'd5);
    check("pos_col08", frog_col, 8'h08);

    row_occ = 8'h08;
    step(1);
    row_occ = 8'h00;
    check("hit_state", game_state, 3'd2);
    check("hit_lives", lives, 2'd2);

    cnt = 0;
    prev_vis = frog_visible;
    for (int i = 0; i < 40 && game_state == 3'd2; i++) begin
      step(1);
      if (frog_visible !== prev_vis) cnt++;
      prev_vis = frog_visible;
    end
    check("dying_toggles", cnt, 4);
    check("respawn_state", game_state, 3'd1);
    check("respawn_row", frog_row, 3'd7);
    check("respawn_col", frog_col, 8'h10);
    check("respawn_vis", frog_visible, 1'b1);

    up_to_row6_and_hit();
    check("hit2_lives", lives, 2'd1);
    wait_state("hit2_back", 3'd1, 40);
    up_to_row6_and_hit();
    check("hit3_lives", lives, 2'd0);
    wait_state("gameover", 3'd4, 40);
    check("go_lives", lives, 2'd0);
    check("go_row", frog_row, 3'd7);
    check("go_col", frog_col, 8'h10);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (lane_step) cnt++;
    end
    check("go_no_lstep", cnt, 0);

    start_pulse();
    check("restart_state", game_state, 3'd1);
    check("restart_lives", lives, 2'd3);
    check("restart_score", score, 8'd0);

    for (int i = 0; i < 7; i++) press(0);
    check("win_state", game_state, 3'd3);
    check("win_score", score, 8'd1);
    check("win_row", frog_row, 3'd0);
    wait_state("win_back", 3'd1, 20);
    check("win_resp_row", frog_row, 3'd7);
    check("win_resp_col", frog_col, 8'h10);

    for (int w = 0; w < 254; w++) begin
      for (int i = 0; i < 7; i++) press(0);
      for (int i = 0; i < 20 && game_state != 3'd1; i++) step(1);
    end
    check("score_255", score, 8'd255);
    for (int i = 0; i < 7; i++) press(0);
    check("sat_state", game_state, 3'd3);
    check("sat_score", score, 8'd255);
    wait_state("sat_back", 3'd1, 20);

    up_to_row6_and_hit();
    check("mid_dying", game_state, 3'd2);
    step(3);
    up = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    reset = 1'b0;
    step(10);
    up = 1'b1;
    step(3);
    check("post_rst_idle", game_state, 3'd0);
    check("post_rst_row", frog_row, 3'd7);
    start_pulse();
    check("post_rst_play", game_state, 3'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
